// File: rtl/bp_pkg.sv
// Shared types and helpers for the 2-bit saturating-counter branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating step: taken moves toward ST, not-taken moves toward SNT.
  function automatic ctr_e sat_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Word address of a PC; callers keep the low IDX_W bits as the table index.
  function automatic logic [29:0] pc_word(input logic [31:0] pc);
    return pc[31:2];
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One predictor table entry: a 2-bit saturating counter with enable and direction.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = 2'b10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);

  ctr_e state_q, state_d;

  // NOTE: default assigned first so every path drives state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (en_i) state_d = sat_next(state_q, taken_i);
  end

  // NOTE: non-blocking assignment for state; each entry is a flop, so the whole table resets.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ctr_e'(INIT_STATE);
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: 2-bit counter table read in ID, carried prediction in ID/EX,
// mispredict detection and table update in EX, plus saturating perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b10,
  parameter int         CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             id_branch_i,
  input  logic [31:0]      id_pc_i,
  input  logic             id_stall_i,
  input  logic             ex_branch_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_taken_i,
  output logic             predict_taken_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [IDX_W-1:0] id_idx, ex_idx;
  logic             upd_en;
  logic [1:0]       table_w [ENTRIES];

  logic             ex_pred_q, ex_pred_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  assign id_idx = IDX_W'(pc_word(id_pc_i));
  assign ex_idx = IDX_W'(pc_word(ex_pc_i));
  assign upd_en = start_i & ex_branch_i;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc_i[1:0], ex_pc_i[1:0]};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bp_sat_counter #(
      .INIT_STATE (INIT_STATE)
    ) u_entry (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (upd_en && (ex_idx == IDX_W'(i))),
      .taken_i (ex_taken_i),
      .state_o (table_w[i])
    );
  end

  // ID reads the registered table, so a same-cycle EX update is not visible yet.
  assign predict_taken_o = start_i & id_branch_i & table_w[id_idx][1];
  assign mispredict_o    = start_i & ex_branch_i & (ex_taken_i ^ ex_pred_q);

  always_comb begin
    ex_pred_d        = ex_pred_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (start_i) begin
      ex_pred_d = (mispredict_o || id_stall_i) ? 1'b0 : predict_taken_o;
      if (ex_branch_i && (branch_cnt_q != '1))
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict_o && (mispredict_cnt_q != '1))
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_pred_q        <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      ex_pred_q        <= ex_pred_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  localparam int IDX_W   = 4;
  localparam int ENTRIES = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst, start, id_branch, id_stall, ex_branch, ex_taken;
  logic [31:0] id_pc, ex_pc;
  logic        predict_taken, mispredict;
  logic [31:0] branch_cnt, mispredict_cnt;

  always #5 clk = ~clk;

  branch_predictor #(
    .IDX_W      (IDX_W),
    .INIT_STATE (2'b10),
    .CNT_W      (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .id_branch_i      (id_branch),
    .id_pc_i          (id_pc),
    .id_stall_i       (id_stall),
    .ex_branch_i      (ex_branch),
    .ex_pc_i          (ex_pc),
    .ex_taken_i       (ex_taken),
    .predict_taken_o  (predict_taken),
    .mispredict_o     (mispredict),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  typedef struct {
    logic        pred;
    logic        mis;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference model: counters as plain integers in 0..3, predict taken when >= 2.
  int      m_tbl [ENTRIES];
  bit      m_ex_pred;
  longint  m_bc, m_mc;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit m_pred();
    return start && id_branch && (m_tbl[idx_of(id_pc)] >= 2);
  endfunction

  function automatic bit m_mis();
    return start && ex_branch && (ex_taken != m_ex_pred);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("predict_taken", 32'(predict_taken), 32'(e.pred));
      check("mispredict", 32'(mispredict), 32'(e.mis));
      check("branch_cnt", branch_cnt, e.bc);
      check("mispredict_cnt", mispredict_cnt, e.mc);
    end
  end

  task automatic model_edge();
    bit p, m;
    int k;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 2;
      m_ex_pred = 0;
      m_bc = 0;
      m_mc = 0;
    end else if (start) begin
      p = m_pred();
      m = m_mis();
      if (ex_branch) begin
        k = idx_of(ex_pc);
        if (ex_taken) m_tbl[k] = (m_tbl[k] < 3) ? m_tbl[k] + 1 : 3;
        else          m_tbl[k] = (m_tbl[k] > 0) ? m_tbl[k] - 1 : 0;
        if (m_bc < CNT_MAX) m_bc++;
      end
      if (m && m_mc < CNT_MAX) m_mc++;
      m_ex_pred = (m || id_stall) ? 1'b0 : p;
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic idb, input logic [31:0] idpc,
                     input logic stl, input logic exb, input logic [31:0] expc, input logic ext,
                     input bit push);
    exp_t e;
    rst = r; start = st; id_branch = idb; id_pc = idpc; id_stall = stl;
    ex_branch = exb; ex_pc = expc; ex_taken = ext;
    if (push) begin
      e.pred = m_pred();
      e.mis  = m_mis();
      e.bc   = m_bc[31:0];
      e.mc   = m_mc[31:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int budget;
    // First reset edge establishes known state; nothing is predictable before it.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Reset held: outputs against reset state; EX taken branch vs ex_pred=0 mispredicts.
    cyc(1, 1, 1, 32'h10, 0, 1, 32'h10, 1, 1);
    // ID branch at 0x10 predicted taken from INIT_STATE, counters at zero.
    cyc(0, 1, 1, 32'h10, 0, 0, 0, 0, 1);
    // Carried taken prediction resolves not-taken: mispredict, entry 4 -> 01.
    cyc(0, 1, 0, 0, 0, 1, 32'h10, 0, 1);
    // Second not-taken with cleared ex_pred: no mispredict, entry 4 -> 00.
    cyc(0, 1, 0, 0, 0, 1, 32'h10, 0, 1);
    cyc(0, 1, 1, 32'h10, 0, 0, 0, 0, 1);
    // Stall while ID branch at 0x20 predicts taken: bubble carries 0.
    cyc(0, 1, 1, 32'h20, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1, 32'h20, 1, 1);
    // Non-branch bubble in EX with taken asserted raises nothing.
    cyc(0, 1, 0, 0, 0, 0, 32'h20, 1, 1);
    // Collision: EX updates 0x10 (10->11) while ID reads aliased 0x50.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 32'h50, 0, 1, 32'h10, 1, 1);
    cyc(0, 1, 1, 32'h50, 0, 0, 0, 0, 1);
    // Pre-update visibility: entry 5 to 01, then 01->10 while ID reads 0x54.
    cyc(0, 1, 0, 0, 0, 1, 32'h14, 0, 1);
    cyc(0, 1, 1, 32'h54, 0, 1, 32'h14, 1, 1);
    cyc(0, 1, 1, 32'h54, 0, 0, 0, 0, 1);
    // start_i low freezes everything and gates both combinational outputs.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h14, 0, 1, 32'h14, 1, 1);
    cyc(0, 1, 1, 32'h14, 0, 1, 32'h14, 1, 1);
    // Randomized traffic over a small PC range with occasional reset and freeze.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
          1'($urandom), {$urandom_range(0, 255), 2'b00} | ($urandom & 32'hFFFF_0003),
          ($urandom_range(0, 5) == 0), 1'($urandom),
          {$urandom_range(0, 255), 2'b00}, 1'($urandom), 1);
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage pipelined RISC-V CPU. It holds a table of 2-bit saturating counters indexed by branch PC. It predicts taken/not-taken for a branch in ID, carries that prediction alongside the ID/EX register, and flags a mispredict when the branch resolves in EX. The outputs drive the CPU's PC-select and IF/ID/ID-EX flush logic, plus branch/mispredict performance counters that the testbench reads in place of the raw flush count.

## Interface
- IDX_W, 4, table index width; 2^IDX_W entries, index = pc[IDX_W+1:2]
- INIT_STATE, 2'b10, counter value after reset (weakly taken)
- CNT_W, 32, width of performance counters
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset synchronous active-high
- start_i  in  1  CPU run enable; 0 freezes all state and forces predict_taken_o=0
- id_branch_i  in  1  instruction in ID is a conditional branch (Control.branch_o)
- id_pc_i  in  32  PC of instruction in ID
- id_stall_i  in  1  hazard-detection stall: ID/EX receives a bubble this cycle
- ex_branch_i  in  1  instruction in EX is a valid branch
- ex_pc_i  in  32  PC of branch in EX
- ex_taken_i  in  1  actual branch outcome computed in EX
- predict_taken_o  out  1  combinational prediction for the ID branch
- mispredict_o  out  1  combinational: EX branch outcome differs from carried prediction
- branch_cnt_o  out  CNT_W  resolved branches since reset
- mispredict_cnt_o  out  CNT_W  mispredicts since reset

## Operation
- Table: 2^IDX_W × 2-bit counters. 00 SNT, 01 WNT, 10 WT, 11 ST.
- Predict: predict_taken_o = start_i & id_branch_i & table[id_idx][1].
- Carry: ex_pred_q is a 1-bit register mirroring the ID/EX stage. Each clock with start_i=1:
  - if mispredict_o or id_stall_i, ex_pred_q <= 0 (flush/bubble)
  - else ex_pred_q <= predict_taken_o
- Resolve: mispredict_o = start_i & ex_branch_i & (ex_taken_i ^ ex_pred_q).
- Update, on each clock with start_i & ex_branch_i:
  - taken: table[ex_idx] increments, saturating at 11
  - not taken: table[ex_idx] decrements, saturating at 00
- Perf counters, on each clock with start_i:
  - branch_cnt increments when ex_branch_i
  - mispredict_cnt increments when mispredict_o
  - both saturate at all-ones; no wrap
- Aliasing: PCs sharing pc[IDX_W+1:2] share one entry; no tags.

## Timing
- Reset (rst_i=1 at a clock edge): every table entry = INIT_STATE; ex_pred_q=0; both counters = 0. rst_i has priority over all other inputs.
- Outputs while rst_i is held: predict_taken_o and mispredict_o follow their combinational definitions against the reset state. With ex_pred_q=0, mispredict_o is 1 only if ex_branch_i and ex_taken_i are asserted.
- Reset mid-operation: all in-flight prediction state is discarded on that edge; there is no partial update.
- Prediction latency: 0 cycles (table read is combinational from registers).
- Update latency: 1 cycle. The counter is written at the edge that ends the EX cycle.
- Same index read in ID while updated from EX in the same cycle: ID sees the pre-update value.
- Mispredict: asserted during the EX cycle of the branch. The CPU redirects the PC and flushes IF/ID and ID/EX at the next edge. ex_pred_q clears at that same edge.
- id_stall_i and mispredict_o both high: ex_pred_q <= 0 (same result).
- start_i=0: no register changes except under rst_i; mispredict_o=0.

## Structure
- Package bp_pkg:
  - typedef for the 2-bit counter state (SNT/WNT/WT/ST)
  - function for the saturating next-state
  - index-extraction helper
- One natural sub-module, bp_sat_counter: a single 2-bit entry with update-enable and direction, instantiated 2^IDX_W times in a generate loop.
- Perf counters are inline; there is no sub-module for them.

## Test plan
- Reset with INIT_STATE=10, then id_branch_i=1 and id_pc_i=0x10 → predict_taken_o=1. Both counters read 0 and ex_pred_q=0.
- Branch at 0x10 resolves not-taken twice (ex_branch_i=1, ex_taken_i=0, two cycles) → entry 4 reaches 00. The next prediction for 0x10 is 0 and mispredict_cnt_o=1.
- Predicted-taken branch moves into EX with ex_taken_i=0 → mispredict_o=1 that cycle, ex_pred_q=0 next cycle, mispredict_cnt_o increments by 1.
- id_stall_i=1 while an ID branch is predicted taken → ex_pred_q=0 next cycle. A non-branch bubble in EX raises no mispredict.
- Same-index collision: EX updates 0x10 (10→11, taken) while ID reads 0x50 (same index with IDX_W=4) → ID prediction uses 10. The next cycle reads 11.
- start_i=0 with ex_branch_i=1 and ex_taken_i=1 for 5 cycles → table, ex_pred_q and counters are unchanged. mispredict_o=0 and predict_taken_o=0 throughout.
